scalar_writeback_unit: RTL and testbench

- Write-back stage directly upstream of the scalar register file.
- Collects scalar results from the ALU and LSU result buses and buffers them in a small in-order FIFO.
- Drains the FIFO one entry at a time into the register file write port (rf_signal, rd, data, write_back_enabled), pacing on the file's rf_status.
- Writes to x0 are dropped at entry.

---
 rtl/scalar_writeback_unit.sv | 147 ++++++++++++++
 tb/tb_scalar_writeback_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/scalar_writeback_unit.sv
// Scalar write-back stage: buffers ALU/LSU results in an in-order FIFO and drains them
// into the register file write port. Optional forwarding search enabled by SCALAR_WB_BYPASS_EN.

`ifndef RF_NOP
`define RF_NOP 2'b00
`endif
`ifndef SCALAR_RF_WRITE
`define SCALAR_RF_WRITE 2'b01
`endif
`ifndef RF_FINISHED
`define RF_FINISHED 2'b10
`endif

module scalar_writeback_unit #(
    parameter int LEN        = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_WIDTH  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy_in,
    input  logic                 alu_valid,
    input  logic [4:0]           alu_rd,
    input  logic [LEN-1:0]       alu_data,
    output logic                 alu_ready,
    input  logic                 lsu_valid,
    input  logic [4:0]           lsu_rd,
    input  logic [LEN-1:0]       lsu_data,
    output logic                 lsu_ready,
    output logic [1:0]           rf_signal,
    output logic [4:0]           rf_rd,
    output logic [LEN-1:0]       rf_data,
    output logic                 write_back_enabled,
    input  logic [1:0]           rf_status,
    output logic [PTR_WIDTH:0]   fifo_count,
    output logic                 busy
`ifdef SCALAR_WB_BYPASS_EN
    ,
    input  logic [4:0]           byp_rs,
    output logic                 byp_hit,
    output logic [LEN-1:0]       byp_data
`endif
);

    localparam logic [PTR_WIDTH:0] L_CNT_M1 = (PTR_WIDTH+1)'(FIFO_DEPTH - 1);
    localparam logic [PTR_WIDTH:0] L_CNT_M2 = (PTR_WIDTH+1)'(FIFO_DEPTH - 2);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [PTR_WIDTH-1:0] r_wptr;
    logic [PTR_WIDTH-1:0] r_rptr;
    logic [PTR_WIDTH:0]   r_count;
    logic [4:0]           r_rd_mem   [FIFO_DEPTH];
    logic [LEN-1:0]       r_data_mem [FIFO_DEPTH];

    logic                 w_lsu_push;
    logic                 w_alu_push;
    logic                 w_pop;
    logic [PTR_WIDTH:0]   w_push_cnt;
    logic [PTR_WIDTH:0]   w_count_nxt;
    logic [PTR_WIDTH-1:0] w_alu_slot;
    logic                 w_issue;

    // Readiness looks only at the registered count; a same-cycle pop does not free space.
    assign lsu_ready = rdy_in && (r_count <= L_CNT_M1);
    assign alu_ready = rdy_in && (lsu_valid ? (r_count <= L_CNT_M2) : (r_count <= L_CNT_M1));

    // rd==0 still handshakes but is never enqueued.
    assign w_lsu_push  = lsu_valid && lsu_ready && (lsu_rd != 5'd0);
    assign w_alu_push  = alu_valid && alu_ready && (alu_rd != 5'd0);
    assign w_pop       = rdy_in && (r_state == StWait) && (rf_status == `RF_FINISHED);
    assign w_push_cnt  = (PTR_WIDTH+1)'(w_lsu_push) + (PTR_WIDTH+1)'(w_alu_push);
    assign w_count_nxt = r_count + w_push_cnt - (PTR_WIDTH+1)'(w_pop);
    assign w_alu_slot  = r_wptr + PTR_WIDTH'(w_lsu_push);

    always_comb begin
        w_state_nxt = r_state;
        if (rdy_in) begin
            case (r_state)
                StIdle:  if (r_count != '0) w_state_nxt = StIssue;
                StIssue: w_state_nxt = StWait;
                StWait: begin
                    if (rf_status == `RF_FINISHED) begin
                        w_state_nxt = (w_count_nxt != '0) ? StIssue : StIdle;
                    end
                end
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (rdy_in) begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_wptr  <= r_wptr + PTR_WIDTH'(w_push_cnt);
            if (w_pop) r_rptr <= r_rptr + 1'b1;
        end
    end

    // LSU is the older entry when both push in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst && w_lsu_push) begin
            r_rd_mem[r_wptr]   <= lsu_rd;
            r_data_mem[r_wptr] <= lsu_data;
        end
        if (!rst && w_alu_push) begin
            r_rd_mem[w_alu_slot]   <= alu_rd;
            r_data_mem[w_alu_slot] <= alu_data;
        end
    end

    assign w_issue            = (r_state == StIssue);
    assign write_back_enabled = w_issue;
    assign rf_signal          = w_issue ? `SCALAR_RF_WRITE : `RF_NOP;
    assign rf_rd              = w_issue ? r_rd_mem[r_rptr] : 5'd0;
    assign rf_data            = w_issue ? r_data_mem[r_rptr] : '0;
    assign fifo_count         = r_count;
    assign busy               = (r_count != '0) || (r_state != StIdle);

`ifdef SCALAR_WB_BYPASS_EN
    logic [PTR_WIDTH-1:0] w_byp_idx;

    // Walk from head to tail so the youngest match overwrites older ones.
    always_comb begin
        byp_hit   = 1'b0;
        byp_data  = '0;
        w_byp_idx = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            w_byp_idx = r_rptr + PTR_WIDTH'(i);
            if (((PTR_WIDTH+1)'(i) < r_count) && (byp_rs != 5'd0) &&
                (r_rd_mem[w_byp_idx] == byp_rs)) begin
                byp_hit  = 1'b1;
                byp_data = r_data_mem[w_byp_idx];
            end
        end
    end
`endif

endmodule

// File: tb/tb_scalar_writeback_unit.sv
// Directed bench for scalar_writeback_unit: vector table plus hand sequences for
// FIFO fill/wrap, rdy_in freeze, mid-ISSUE reset and (optional) bypass search.

`ifndef RF_NOP
`define RF_NOP 2'b00
`endif
`ifndef SCALAR_RF_WRITE
`define SCALAR_RF_WRITE 2'b01
`endif
`ifndef RF_FINISHED
`define RF_FINISHED 2'b10
`endif

module tb_scalar_writeback_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy_in;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        lsu_valid;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        lsu_ready;
    logic [1:0]  rf_signal;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;
    logic        write_back_enabled;
    logic [1:0]  rf_status;
    logic [2:0]  fifo_count;
    logic        busy;
`ifdef SCALAR_WB_BYPASS_EN
    logic [4:0]  byp_rs;
    logic        byp_hit;
    logic [31:0] byp_data;
`endif

    scalar_writeback_unit dut (
        .clk                (clk),
        .rst                (rst),
        .rdy_in             (rdy_in),
        .alu_valid          (alu_valid),
        .alu_rd             (alu_rd),
        .alu_data           (alu_data),
        .alu_ready          (alu_ready),
        .lsu_valid          (lsu_valid),
        .lsu_rd             (lsu_rd),
        .lsu_data           (lsu_data),
        .lsu_ready          (lsu_ready),
        .rf_signal          (rf_signal),
        .rf_rd              (rf_rd),
        .rf_data            (rf_data),
        .write_back_enabled (write_back_enabled),
        .rf_status          (rf_status),
        .fifo_count         (fifo_count),
        .busy               (busy)
`ifdef SCALAR_WB_BYPASS_EN
        ,
        .byp_rs             (byp_rs),
        .byp_hit            (byp_hit),
        .byp_data           (byp_data)
`endif
    );

    always #5 clk = ~clk;

    // Register-file model fed by the write port.
    logic [31:0] shadow [32];
    int          n_wb;
    always @(posedge clk) begin
        if (rst) n_wb <= 0;
        else if (write_back_enabled) begin
            shadow[rf_rd] <= rf_data;
            n_wb          <= n_wb + 1;
        end
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldat;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic [1:0]  st;
        logic        e_ar;
        logic        e_lr;
        logic [2:0]  e_cnt;
        logic        e_wbe;
        logic [4:0]  e_rd;
        logic [31:0] e_dat;
    } vec_t;

    localparam logic [1:0] NOP = `RF_NOP;
    localparam logic [1:0] FIN = `RF_FINISHED;
    localparam logic [1:0] WR  = `SCALAR_RF_WRITE;

    vec_t vecs [13];

    initial begin
        // lv lrd ldat    av ard adat          st   ar lr cnt wbe rd dat
        vecs[0]  = '{0, 0, 0,     1, 5, 32'hDEADBEEF, NOP, 1, 1, 1, 0, 0, 0};
        vecs[1]  = '{0, 0, 0,     0, 0, 0,            NOP, 1, 1, 1, 1, 5, 32'hDEADBEEF};
        vecs[2]  = '{0, 0, 0,     0, 0, 0,            NOP, 1, 1, 1, 0, 0, 0};
        vecs[3]  = '{0, 0, 0,     0, 0, 0,            FIN, 1, 1, 0, 0, 0, 0};
        vecs[4]  = '{0, 0, 0,     0, 0, 0,            NOP, 1, 1, 0, 0, 0, 0};
        vecs[5]  = '{1, 3, 32'h11, 1, 3, 32'h22,      NOP, 1, 1, 2, 0, 0, 0};
        vecs[6]  = '{0, 0, 0,     0, 0, 0,            NOP, 1, 1, 2, 1, 3, 32'h11};
        vecs[7]  = '{0, 0, 0,     0, 0, 0,            NOP, 1, 1, 2, 0, 0, 0};
        vecs[8]  = '{0, 0, 0,     0, 0, 0,            FIN, 1, 1, 1, 1, 3, 32'h22};
        vecs[9]  = '{0, 0, 0,     0, 0, 0,            NOP, 1, 1, 1, 0, 0, 0};
        vecs[10] = '{0, 0, 0,     0, 0, 0,            FIN, 1, 1, 0, 0, 0, 0};
        vecs[11] = '{0, 0, 0,     1, 0, 32'h1234,     NOP, 1, 1, 0, 0, 0, 0};
        vecs[12] = '{0, 0, 0,     0, 0, 0,            NOP, 1, 1, 0, 0, 0, 0};

        rst = 1'b1; rdy_in = 1'b1;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        rf_status = NOP;
`ifdef SCALAR_WB_BYPASS_EN
        byp_rs = 0;
`endif
        step();
        step();
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_wbe", 32'(write_back_enabled), 0);
        chk("rst_sig", 32'(rf_signal), 32'(NOP));
        chk("rst_busy", 32'(busy), 0);
        chk("rst_alu_ready", 32'(alu_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        step();

        for (int i = 0; i < 13; i++) begin
            lsu_valid = vecs[i].lv; lsu_rd = vecs[i].lrd; lsu_data = vecs[i].ldat;
            alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_data = vecs[i].adat;
            rf_status = vecs[i].st;
            #1;
            chk($sformatf("v%0d_alu_ready", i), 32'(alu_ready), 32'(vecs[i].e_ar));
            chk($sformatf("v%0d_lsu_ready", i), 32'(lsu_ready), 32'(vecs[i].e_lr));
            step();
            chk($sformatf("v%0d_count", i), 32'(fifo_count), 32'(vecs[i].e_cnt));
            chk($sformatf("v%0d_wbe", i), 32'(write_back_enabled), 32'(vecs[i].e_wbe));
            chk($sformatf("v%0d_sig", i), 32'(rf_signal), vecs[i].e_wbe ? 32'(WR) : 32'(NOP));
            chk($sformatf("v%0d_rd", i), 32'(rf_rd), 32'(vecs[i].e_rd));
            chk($sformatf("v%0d_data", i), rf_data, vecs[i].e_dat);
        end
        chk("last_write_wins_r3", shadow[3], 32'h22);
        chk("writes_after_table", 32'(n_wb), 3);

        // Fill to depth with the register file stalled; pointers start at 3 so this wraps.
        lsu_valid = 1; lsu_rd = 1; lsu_data = 32'h101;
        alu_valid = 1; alu_rd = 2; alu_data = 32'h102;
        rf_status = NOP;
        #1;
        chk("fill0_ready", 32'({lsu_ready, alu_ready}), 32'b11);
        step();
        chk("fill0_count", 32'(fifo_count), 2);
        lsu_rd = 3; lsu_data = 32'h103;
        alu_rd = 4; alu_data = 32'h104;
        #1;
        chk("fill1_ready", 32'({lsu_ready, alu_ready}), 32'b11);
        step();
        chk("fill1_count", 32'(fifo_count), 4);
        chk("fill1_issue_rd", 32'(rf_rd), 1);
        chk("fill1_issue_data", rf_data, 32'h101);
        lsu_rd = 5; alu_rd = 6;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("full%0d_ready", i), 32'({lsu_ready, alu_ready}), 0);
            step();
            chk($sformatf("full%0d_count", i), 32'(fifo_count), 4);
            chk($sformatf("full%0d_wbe", i), 32'(write_back_enabled), 0);
        end
        lsu_valid = 0; alu_valid = 0;
        for (int k = 0; k < 4; k++) begin
            rf_status = FIN;
            step();
            chk($sformatf("drain%0d_count", k), 32'(fifo_count), 32'(3 - k));
            if (k < 3) begin
                chk($sformatf("drain%0d_wbe", k), 32'(write_back_enabled), 1);
                chk($sformatf("drain%0d_rd", k), 32'(rf_rd), 32'(k + 2));
                chk($sformatf("drain%0d_data", k), rf_data, 32'h102 + 32'(k));
            end else begin
                chk("drain3_wbe", 32'(write_back_enabled), 0);
            end
            rf_status = NOP;
            step();
        end
        chk("drain_r4", shadow[4], 32'h104);
        chk("drain_writes", 32'(n_wb), 7);

        // Freeze with rdy_in low while in WAIT.
        alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
        step();
        alu_valid = 0;
        step();
        step();
        chk("pre_freeze_count", 32'(fifo_count), 1);
        rdy_in = 0; alu_valid = 1; alu_rd = 10; alu_data = 32'hAA; rf_status = FIN;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("frz%0d_ready", i), 32'({lsu_ready, alu_ready}), 0);
            step();
            chk($sformatf("frz%0d_count", i), 32'(fifo_count), 1);
            chk($sformatf("frz%0d_wbe", i), 32'(write_back_enabled), 0);
            chk($sformatf("frz%0d_busy", i), 32'(busy), 1);
        end
        rdy_in = 1; alu_valid = 0;
        step();
        chk("unfreeze_count", 32'(fifo_count), 0);
        chk("unfreeze_busy", 32'(busy), 0);
        chk("freeze_writes", 32'(n_wb), 8);
        rf_status = NOP;

        // Reset asserted while an entry is in ISSUE.
        alu_valid = 1; alu_rd = 11; alu_data = 32'hBB;
        step();
        alu_valid = 0;
        step();
        chk("pre_rst_wbe", 32'(write_back_enabled), 1);
        chk("pre_rst_rd", 32'(rf_rd), 11);
        #2;
        rst = 1;
        #1;
        chk("midrst_wbe", 32'(write_back_enabled), 0);
        chk("midrst_sig", 32'(rf_signal), 32'(NOP));
        chk("midrst_rd", 32'(rf_rd), 0);
        chk("midrst_count", 32'(fifo_count), 0);
        @(negedge clk);
        rst = 0;
        step();
        chk("post_rst_wbe", 32'(write_back_enabled), 0);
        step();
        chk("post_rst_wbe2", 32'(write_back_enabled), 0);
        chk("post_rst_busy", 32'(busy), 0);

`ifdef SCALAR_WB_BYPASS_EN
        lsu_valid = 1; lsu_rd = 7; lsu_data = 32'hA;
        alu_valid = 1; alu_rd = 7; alu_data = 32'hB;
        step();
        lsu_valid = 0; alu_valid = 0;
        byp_rs = 7;
        #1;
        chk("byp7_hit", 32'(byp_hit), 1);
        chk("byp7_data", byp_data, 32'hB);
        byp_rs = 0;
        #1;
        chk("byp0_hit", 32'(byp_hit), 0);
        chk("byp0_data", byp_data, 0);
        byp_rs = 8;
        #1;
        chk("byp8_hit", 32'(byp_hit), 0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
